mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the CPU instruction-fetch port and the CPU data port.
- Sits between the CPU core and the memory model.
- Serialises requests with round-robin priority and drives a stall to the core while any requested access is outstanding.
- Adds a watchdog that flags a memory that never acknowledges.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, maximum cycles in a busy state without mem_ack before the error is raised

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset (asserted when 0)
- i_req  in  1  fetch request, held until i_done
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetched word, valid when i_done=1
- i_done  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, held until d_done
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_we  in  4  byte write enables; 0 means load
- d_rdata  out  DW  load data, valid when d_done=1
- d_done  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_we  out  4  memory byte enables
- mem_ack  in  1  memory completion; read data valid in the same cycle
- mem_rdata  in  DW  memory read data
- stall  out  1  core hold
- timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_grant=DATA (so fetch wins first), timer=0.
  - All outputs 0: mem_req, mem_addr, mem_wdata, mem_we, i_done, d_done, i_rdata, d_rdata, timeout_err.
- States: IDLE, I_BUSY, D_BUSY, ERR.
- IDLE:
  - Only i_req set -> I_BUSY. Only d_req set -> D_BUSY.
  - Both set -> grant the requester not equal to last_grant.
  - Neither set -> stay in IDLE.
  - Register mem_addr, mem_wdata and mem_we from the granted requester on entry (mem_we and mem_wdata are 0 for fetch). Raise mem_req on the next cycle.
- I_BUSY / D_BUSY:
  - mem_req=1 and the memory-side outputs stay constant.
  - On mem_ack: capture mem_rdata into i_rdata or d_rdata, pulse the matching done for one cycle, update last_grant, clear timer, return to IDLE.
  - mem_req drops in the ack cycle + 1.
  - Minimum latency: request seen in IDLE at cycle N, mem_req at N+1, ack at N+1 gives done at N+2.
- Back-to-back: an IDLE cycle always separates grants. A requester whose req stays high after its done is treated as a new request.
- mem_ack while in IDLE is ignored.
- stall = (i_req & ~i_done) | (d_req & ~d_done), combinational.
- Watchdog:
  - timer increments each busy cycle without mem_ack.
  - When timer reaches TIMEOUT: go to ERR, set timeout_err=1, mem_req=0, no done pulse.
  - ERR is left only by reset, and stall stays asserted while any request is pending.
  - The timer saturates and never wraps.
- Requester dropping req mid-transaction is illegal; the arbiter still completes the transaction and pulses done.
- Reset mid-transaction aborts immediately: mem_req=0, no done pulse.
- i_rdata and d_rdata hold their last captured value between transactions.

Decomposition:
- Shared package cpu_mem_pkg: state encoding (IDLE=0, I_BUSY=1, D_BUSY=2, ERR=3), grant-id constants (GNT_I=0, GNT_D=1), WE_NONE=4'b0000.
- One natural sub-module, rr_arb2: 2-way round-robin pick from (i_req, d_req, last_grant).
- Watchdog counter lives inline.

Test Plan:
- Fetch only: i_addr=0x10, mem_ack one cycle after mem_req with mem_rdata=0x00500093 -> mem_addr=0x10, mem_we=0, i_done pulse with i_rdata=0x00500093, stall high until the done cycle.
- Store only: d_addr=0x100, d_wdata=0xDEADBEEF, d_we=4'hF, ack after 3 cycles -> mem_we=4'hF, mem_wdata=0xDEADBEEF held constant for 3 cycles, single d_done pulse.
- Simultaneous i_req and d_req straight out of reset -> fetch granted first, then data. Repeat with both held -> grants alternate I, D, I, D.
- Load during a fetch: d_req rises while I_BUSY -> data not granted until after i_done plus one IDLE cycle; d_rdata equals mem_rdata at its ack.
- Timeout with TIMEOUT=8: i_req, mem_ack never asserted -> after 8 busy cycles timeout_err=1, mem_req=0, no i_done, stall stays 1; reset low clears everything.
- Reset asserted asynchronously mid D_BUSY -> mem_req and all outputs 0 before the next clock edge; the following transaction is fetch-first.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU <-> unified memory arbiter.
//   state_t  : arbiter FSM encoding
//   GNT_I/D  : grant identifiers (also stored as last_grant)
//   WE_NONE  : byte-enable value for a read access
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam logic       GNT_I   = 1'b0;
  localparam logic       GNT_D   = 1'b1;
  localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between the fetch and data ports.
//   i_req, d_req : pending requests
//   last_grant   : port served most recently (GNT_I / GNT_D)
//   gnt_vld      : at least one request pending
//   gnt          : chosen port; on contention the port that did not go last
module rr_arb2
  import cpu_mem_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic gnt_vld,
  output logic gnt
);

  assign gnt_vld = i_req | d_req;

  always_comb begin
    gnt = GNT_I;
    if (i_req && d_req)
      gnt = (last_grant == GNT_I) ? GNT_D : GNT_I;
    else if (d_req)
      gnt = GNT_D;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU fetch and data accesses onto one single-ported memory.
//   clk, reset            : clock, async active-low reset
//   i_req/i_addr          : fetch request, held until i_done
//   i_rdata/i_done        : fetched word + one-cycle completion pulse
//   d_req/d_addr/d_wdata/d_we : data request (d_we=0 means load)
//   d_rdata/d_done        : load data + one-cycle completion pulse
//   mem_*                 : memory-side request; mem_ack completes it,
//                           with mem_rdata valid in the ack cycle
//   stall                 : core hold while any access is outstanding
//   timeout_err           : sticky, memory never acknowledged
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_we,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_we,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  output logic          timeout_err
);

  localparam int            TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] T_TRIP = TW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic          last_grant, last_grant_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          mem_req_nxt, i_done_nxt, d_done_nxt, timeout_err_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
  logic [3:0]    mem_we_nxt;
  logic          gnt_vld, gnt;

  // A port's req in its own done cycle is the request that just finished,
  // not a new one; masking it avoids re-issuing the same access.
  rr_arb2 u_arb (
    .i_req      (i_req & ~i_done),
    .d_req      (d_req & ~d_done),
    .last_grant (last_grant),
    .gnt_vld    (gnt_vld),
    .gnt        (gnt)
  );

  assign stall = (i_req & ~i_done) | (d_req & ~d_done);

  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    timer_nxt       = timer;
    mem_req_nxt     = mem_req;
    mem_addr_nxt    = mem_addr;
    mem_wdata_nxt   = mem_wdata;
    mem_we_nxt      = mem_we;
    i_rdata_nxt     = i_rdata;
    d_rdata_nxt     = d_rdata;
    i_done_nxt      = 1'b0;
    d_done_nxt      = 1'b0;
    timeout_err_nxt = timeout_err;

    unique case (state)
      IDLE: begin
        // mem_ack here is stale/spurious and deliberately ignored
        if (gnt_vld) begin
          mem_req_nxt = 1'b1;
          timer_nxt   = '0;
          if (gnt == GNT_I) begin
            state_nxt     = I_BUSY;
            mem_addr_nxt  = i_addr;
            mem_wdata_nxt = '0;
            mem_we_nxt    = WE_NONE;
          end else begin
            state_nxt     = D_BUSY;
            mem_addr_nxt  = d_addr;
            mem_wdata_nxt = d_wdata;
            mem_we_nxt    = d_we;
          end
        end
      end

      I_BUSY, D_BUSY: begin
        if (mem_ack) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          timer_nxt   = '0;
          if (state == I_BUSY) begin
            i_done_nxt     = 1'b1;
            i_rdata_nxt    = mem_rdata;
            last_grant_nxt = GNT_I;
          end else begin
            d_done_nxt     = 1'b1;
            d_rdata_nxt    = mem_rdata;
            last_grant_nxt = GNT_D;
          end
        end else if (timer >= T_TRIP) begin
          // This cycle makes TIMEOUT busy cycles without an ack
          state_nxt       = ERR;
          mem_req_nxt     = 1'b0;
          timeout_err_nxt = 1'b1;
          timer_nxt       = T_MAX;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      ERR: begin
        // Terminal until reset; timer stays saturated
        mem_req_nxt = 1'b0;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= GNT_D;
      timer       <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= WE_NONE;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      timer       <= timer_nxt;
      mem_req     <= mem_req_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_wdata   <= mem_wdata_nxt;
      mem_we      <= mem_we_nxt;
      i_rdata     <= i_rdata_nxt;
      d_rdata     <= d_rdata_nxt;
      i_done      <= i_done_nxt;
      d_done      <= d_done_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

endmodule
